des_block_sequencer: RTL and testbench
======================================

Name: des_block_sequencer

Overview:
- Host-side driver for triple_DES_block; the other end of the core's enable/done/data interface.
- Accepts 64-bit blocks from upstream over valid/ready and presents each block and its mode to the core with core_enable held high.
- Waits for core_done, captures the core result and returns it downstream over valid/ready.
- Sits between the bus/FIFO front end and the 3DES core; detects a hung core by timeout.

Parameters:
TIMEOUT_CYCLES, 64, cycles in RUN without core_done before the block is aborted; legal range 2..65535.
CNT_W, 16, width of the RUN cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  upstream block valid
in_ready  output  1  sequencer can accept a block
in_data  input  64  plaintext or ciphertext block
in_encr_decr  input  1  1=encrypt, 0=decrypt; sampled with in_data
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  64  result block
core_enable  output  1  to core enable
core_encr_decr  output  1  to core encr_decr
core_input_block  output  64  to core input_data_block
core_done  input  1  from core done
core_output_block  input  64  from core output_data_block
busy  output  1  high in any state other than IDLE
timeout_err  output  1  sticky, set on abort
err_clr  input  1  synchronous clear of timeout_err

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out_data=0, core_enable=0, core_encr_decr=0, core_input_block=0, busy=0, timeout_err=0, counter=0.
  - Reset mid-operation aborts silently; no output is produced.
- All outputs are registered.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into core_input_block and in_encr_decr into core_encr_decr; set core_enable=1, counter=0; go to RUN.
- RUN:
  - in_ready=0; core_enable=1; core_input_block and core_encr_decr held stable.
  - Counter increments every cycle.
  - core_done=1: capture core_output_block into out_data, set out_valid=1, core_enable=0, go to HOLD.
  - Otherwise, when counter==TIMEOUT_CYCLES-1: set timeout_err=1, core_enable=0, discard the block, go to IDLE.
  - If core_done and the timeout coincide, core_done wins and timeout_err is not set.
- HOLD:
  - out_valid=1; out_data stable.
  - On out_ready: out_valid=0, go to IDLE.
  - in_ready=0 throughout HOLD. There is no overlap of blocks.
- core_done is ignored in IDLE and HOLD.
- Latency: in_data accepted at edge N → core_enable high from edge N. If core_done is high in the cycle ending at edge N+K, out_valid rises at edge N+K.
- Throughput: one block in flight at a time. Minimum turnaround is one IDLE cycle after the out_ready handshake.
- timeout_err:
  - Cleared by err_clr at the next edge.
  - A set event and err_clr in the same cycle: set wins.
- in_valid held while in_ready=0 is legal; in_data is not sampled.

Optional Feature:
- Macro CBC_MODE_EN.
- Defined: adds ports iv (input, 64) and iv_load (input, 1), and a 64-bit chain register (reset 0).
  - iv_load in IDLE loads chain<=iv. iv_load in other states is ignored. If iv_load and an accept occur in the same IDLE cycle, the accept uses the old chain and the iv is loaded.
  - Encrypt: core_input_block=in_data^chain; on done, chain<=core_output_block and out_data=core_output_block.
  - Decrypt: core_input_block=in_data; on done, out_data=core_output_block^chain and chain<=latched in_data.
  - A timeout leaves chain unchanged.
- Undefined: ECB only. iv, iv_load and the chain register do not exist; data passes unmodified.

Test Plan:
- Stub core: after 16 cycles of enable, asserts done for 1 cycle with output=input^FFFF0000FFFF0000.
- ECB encrypt: in_data=5368656C6C73686F, encr=1, out_ready=1 → core_encr_decr=1, core_enable high 16 cycles, out_data=AC97656C938C686F with out_valid for 1 cycle.
- Backpressure: same block with out_ready=0 for 10 cycles → out_valid and out_data=AC97656C938C686F stable, in_ready=0, busy=1; releases on the out_ready cycle; in_ready=1 one cycle later.
- Timeout: stub never asserts done, TIMEOUT_CYCLES=64 → timeout_err=1 exactly 64 cycles after accept, core_enable=0, out_valid never asserted, in_ready=1; err_clr pulse → timeout_err=0.
- Race and reset:
  - done on the timeout cycle (stub latency 64) → out_valid=1, timeout_err=0.
  - rst pulsed in RUN → all outputs 0, in_ready=1, no output delivered.
- CBC_MODE_EN:
  - iv=0000000000000001.
  - Encrypt 5368656C6C73686F → core_input_block=5368656C6C73686E, out_data=AC97656C938C686E.
  - Next block 0000000000000000 → core_input_block=AC97656C938C686E, out_data=5368656C6C73686E.
  - Reload iv, decrypt the two results → original plaintexts recovered.

Source files
------------

// File: rtl/des_seq_if.sv
// Bundle of the des_block_sequencer handshake, core and status signals.
// Build option CBC_MODE_EN adds the iv/iv_load chaining inputs.
// master: host/environment side; slave: the sequencer itself.
interface des_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_encr_decr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        core_enable;
    logic        core_encr_decr;
    logic [63:0] core_input_block;
    logic        core_done;
    logic [63:0] core_output_block;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;
`ifdef CBC_MODE_EN
    logic [63:0] iv;
    logic        iv_load;
`endif

    modport master (
        output in_valid, in_data, in_encr_decr, out_ready, core_done, core_output_block,
               err_clr,
`ifdef CBC_MODE_EN
               iv, iv_load,
`endif
        input  in_ready, out_valid, out_data, core_enable, core_encr_decr, core_input_block,
               busy, timeout_err
    );

    modport slave (
        input  in_valid, in_data, in_encr_decr, out_ready, core_done, core_output_block,
               err_clr,
`ifdef CBC_MODE_EN
               iv, iv_load,
`endif
        output in_ready, out_valid, out_data, core_enable, core_encr_decr, core_input_block,
               busy, timeout_err
    );
endinterface

// File: rtl/des_block_sequencer.sv
// Host-side driver for the triple-DES core: accepts one 64-bit block, runs the core until done
// (or aborts on timeout), then returns the result over valid/ready. One block in flight.
// Build option CBC_MODE_EN enables cipher-block chaining with a loadable IV.
module des_block_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input logic      clk,
    input logic      rst,
    des_seq_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StHold} state_t;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [63:0]        out_data_q, out_data_d;
    logic               core_enable_q, core_enable_d;
    logic               core_encr_q, core_encr_d;
    logic [63:0]        core_block_q, core_block_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_set;
`ifdef CBC_MODE_EN
    logic [63:0]        chain_q, chain_d;
`endif

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        state_d       = state_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        core_enable_d = core_enable_q;
        core_encr_d   = core_encr_q;
        core_block_d  = core_block_q;
        cnt_d         = cnt_q;
        timeout_set   = 1'b0;
`ifdef CBC_MODE_EN
        chain_d       = chain_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef CBC_MODE_EN
                if (bus.iv_load) chain_d = bus.iv;
`endif
                if (bus.in_valid && in_ready_q) begin
                    core_encr_d   = bus.in_encr_decr;
`ifdef CBC_MODE_EN
                    // Accept uses the chain value from before any same-cycle IV load.
                    core_block_d  = bus.in_encr_decr ? (bus.in_data ^ chain_q) : bus.in_data;
`else
                    core_block_d  = bus.in_data;
`endif
                    core_enable_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CNT_W'(1);
                // core_done has priority over a coincident timeout.
                if (bus.core_done) begin
                    core_enable_d = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = StHold;
`ifdef CBC_MODE_EN
                    if (core_encr_q) begin
                        out_data_d = bus.core_output_block;
                        chain_d    = bus.core_output_block;
                    end else begin
                        out_data_d = bus.core_output_block ^ chain_q;
                        chain_d    = core_block_q;
                    end
`else
                    out_data_d    = bus.core_output_block;
`endif
                end else if (cnt_q == CntLast) begin
                    timeout_set   = 1'b1;
                    core_enable_d = 1'b0;
                    state_d       = StIdle;
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Sticky error: a set event beats a same-cycle clear.
        timeout_d = timeout_q;
        if (bus.err_clr) timeout_d = 1'b0;
        if (timeout_set) timeout_d = 1'b1;

        in_ready_d = (state_d == StIdle);
        busy_d     = (state_d != StIdle);
    end

    // State and output registers with asynchronous reset to the idle condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            core_enable_q <= 1'b0;
            core_encr_q   <= 1'b0;
            core_block_q  <= '0;
            busy_q        <= 1'b0;
            timeout_q     <= 1'b0;
            cnt_q         <= '0;
`ifdef CBC_MODE_EN
            chain_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            core_enable_q <= core_enable_d;
            core_encr_q   <= core_encr_d;
            core_block_q  <= core_block_d;
            busy_q        <= busy_d;
            timeout_q     <= timeout_d;
            cnt_q         <= cnt_d;
`ifdef CBC_MODE_EN
            chain_q       <= chain_d;
`endif
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.out_data         = out_data_q;
    assign bus.core_enable      = core_enable_q;
    assign bus.core_encr_decr   = core_encr_q;
    assign bus.core_input_block = core_block_q;
    assign bus.busy             = busy_q;
    assign bus.timeout_err      = timeout_q;
endmodule

// File: tb/tb_des_block_sequencer.sv
// Bench for des_block_sequencer: stub core, randomized traffic, scoreboard monitor.
// Build option CBC_MODE_EN selects the chaining tests.
module tb_des_block_sequencer;
    localparam int unsigned TO = 64;
    localparam logic [63:0] KMASK = 64'hFFFF0000FFFF0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    des_seq_if bus();

    des_block_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub core: done in the lat-th enabled cycle; random done noise while not enabled.
    int unsigned stub_lat = 16;
    bit          stub_hang = 1'b0;
    int unsigned stub_cnt;
    bit          noise = 1'b0;
    always @(posedge clk or posedge rst)
        if (rst) stub_cnt <= 0;
        else if (!bus.core_enable) stub_cnt <= 0;
        else stub_cnt <= stub_cnt + 1;
    always @(negedge clk) noise <= 1'($urandom_range(0, 1));
    assign bus.core_done = bus.core_enable ? (!stub_hang && (stub_cnt == stub_lat - 1)) : noise;
    assign bus.core_output_block = bus.core_input_block ^ KMASK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected result and the cycle out_valid must rise.
    typedef struct {
        logic [63:0] data;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    logic [63:0] cur_blk = '0;
    logic        cur_mode = 1'b0;
    logic [63:0] last_out = '0;
    int unsigned last_hold = 0;
`ifdef CBC_MODE_EN
    logic [63:0] chain = '0;
    bit          pend_ld = 1'b0;
    logic [63:0] pend_iv = '0;
`endif

    // Downstream ready: forced low for bp_hold cycles of out_valid, else random or always high.
    int unsigned bp_hold = 0;
    bit          rdy_always = 1'b0;
    always @(posedge clk) begin
        #1;
        if (bp_hold > 0) begin
            bus.out_ready = 1'b0;
            if (bus.out_valid) bp_hold--;
        end else begin
            bus.out_ready = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: checks core-side stability and every presented result against the scoreboard.
    bit          prev_valid = 1'b0;
    bit          after_hs = 1'b0;
    int unsigned valid_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
            after_hs   <= 1'b0;
            valid_run  <= 0;
        end else begin
            if (after_hs) begin
                chk("in_ready after release", 64'(bus.in_ready), 64'd1);
                chk("out_valid after release", 64'(bus.out_valid), 64'd0);
            end
            if (bus.core_enable) begin
                chk("core_input_block", bus.core_input_block, cur_blk);
                chk("core_encr_decr", 64'(bus.core_encr_decr), 64'(cur_mode));
                chk("busy in run", 64'(bus.busy), 64'd1);
                chk("in_ready in run", 64'(bus.in_ready), 64'd0);
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious out_valid", 64'(bus.out_valid), 64'd0);
                    after_hs <= 1'b0;
                end else begin
                    if (!prev_valid) begin
                        chk("latency", 64'(cyc), 64'(sb[0].due));
                        chk("timeout_err on done", 64'(bus.timeout_err), 64'd0);
                        chk("core_enable on done", 64'(bus.core_enable), 64'd0);
                    end
                    chk("out_data", bus.out_data, sb[0].data);
                    chk("busy in hold", 64'(bus.busy), 64'd1);
                    chk("in_ready in hold", 64'(bus.in_ready), 64'd0);
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        last_out  <= bus.out_data;
                        last_hold <= valid_run + 1;
                    end
                    after_hs <= bus.out_ready;
                end
            end else begin
                after_hs <= 1'b0;
            end
            valid_run  <= bus.out_valid ? valid_run + 1 : 0;
            prev_valid <= bus.out_valid;
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, " out_data"}, bus.out_data, 64'd0);
        chk({tag, " core_enable"}, 64'(bus.core_enable), 64'd0);
        chk({tag, " core_encr_decr"}, 64'(bus.core_encr_decr), 64'd0);
        chk({tag, " core_input_block"}, bus.core_input_block, 64'd0);
        chk({tag, " busy"}, 64'(bus.busy), 64'd0);
        chk({tag, " timeout_err"}, 64'(bus.timeout_err), 64'd0);
    endtask

    // Issue one block; hang=1 means the stub never answers and a timeout is expected.
    task automatic send(input logic [63:0] d, input logic m, input int unsigned lat,
                        input bit hang, input bit early_clr);
        logic [63:0] cin;
        logic [63:0] res;
        int unsigned acc;
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            bus.in_valid     = 1'($urandom_range(0, 1));
            bus.in_data      = {$urandom, $urandom};
            bus.in_encr_decr = 1'($urandom_range(0, 1));
`ifdef CBC_MODE_EN
            bus.iv_load      = 1'($urandom_range(0, 1));
            bus.iv           = {$urandom, $urandom};
`endif
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready wait", 64'(bus.in_ready), 64'd1);
            return;
        end
        stub_lat  = lat;
        stub_hang = hang;
`ifdef CBC_MODE_EN
        if (m) begin
            cin = d ^ chain;
            res = cin ^ KMASK;
        end else begin
            cin = d;
            res = (d ^ KMASK) ^ chain;
        end
        bus.iv_load = pend_ld;
        bus.iv      = pend_iv;
        if (pend_ld) chain = pend_iv;
        if (!hang) chain = m ? res : d;
        pend_ld = 1'b0;
`else
        cin = d;
        res = d ^ KMASK;
`endif
        cur_blk          = cin;
        cur_mode         = m;
        bus.in_valid     = 1'b1;
        bus.in_data      = d;
        bus.in_encr_decr = m;
        acc = cyc + 1;
        if (!hang) sb.push_back('{res, acc + lat});
        @(negedge clk);
        bus.in_valid = 1'b0;
`ifdef CBC_MODE_EN
        bus.iv_load  = 1'b0;
`endif
        if (hang) begin
            if (early_clr) bus.err_clr = 1'b1;
            n = 0;
            while (!bus.timeout_err && n < int'(TO) + 10) begin
                @(negedge clk);
                n++;
            end
            chk("timeout cycle", 64'(cyc), 64'(acc + TO));
            chk("timeout_err set", 64'(bus.timeout_err), 64'd1);
            chk("core_enable after timeout", 64'(bus.core_enable), 64'd0);
            chk("in_ready after timeout", 64'(bus.in_ready), 64'd1);
            chk("out_valid after timeout", 64'(bus.out_valid), 64'd0);
            chk("busy after timeout", 64'(bus.busy), 64'd0);
            bus.err_clr = 1'b1;
            @(negedge clk);
            bus.err_clr = 1'b0;
            chk("timeout_err cleared", 64'(bus.timeout_err), 64'd0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        if (sb.size() != 0) chk("drain", 64'(sb.size()), 64'd0);
    endtask

`ifdef CBC_MODE_EN
    task automatic load_iv(input logic [63:0] v);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        bus.iv      = v;
        bus.iv_load = 1'b1;
        chain       = v;
        @(negedge clk);
        bus.iv_load = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r;
        int unsigned lat;
        bit          hang;
        bit          ec;
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.in_encr_decr = 1'b0;
        bus.out_ready    = 1'b0;
        bus.err_clr      = 1'b0;
`ifdef CBC_MODE_EN
        bus.iv           = '0;
        bus.iv_load      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_idle("in reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle("after reset");

        rdy_always = 1'b1;
`ifdef CBC_MODE_EN
        load_iv(64'h0000000000000001);
        send(64'h5368656C6C73686F, 1'b1, 16, 1'b0, 1'b0);
        drain();
        chk("cbc enc block 1", last_out, 64'hAC97656C938C686E);
        send(64'h0000000000000000, 1'b1, 16, 1'b0, 1'b0);
        drain();
        chk("cbc enc block 2", last_out, 64'h5368656C6C73686E);
        load_iv(64'h0000000000000001);
        send(64'hAC97656C938C686E, 1'b0, 16, 1'b0, 1'b0);
        drain();
        chk("cbc dec block 1", last_out, 64'h5368656C6C73686F);
        send(64'h5368656C6C73686E, 1'b0, 16, 1'b0, 1'b0);
        drain();
        chk("cbc dec block 2", last_out, 64'h0000000000000000);
`else
        send(64'h5368656C6C73686F, 1'b1, 16, 1'b0, 1'b0);
        drain();
        chk("ecb vector", last_out, 64'hAC97656C938C686F);
        chk("ecb valid cycles", 64'(last_hold), 64'd1);
        bp_hold = 10;
        send(64'h5368656C6C73686F, 1'b1, 16, 1'b0, 1'b0);
        drain();
        chk("backpressure vector", last_out, 64'hAC97656C938C686F);
        chk("backpressure valid cycles", 64'(last_hold), 64'd11);
`endif
        rdy_always = 1'b0;

        // Timeout, set-beats-clear, and done coinciding with the timeout cycle.
        send({$urandom, $urandom}, 1'b1, 16, 1'b1, 1'b0);
        send({$urandom, $urandom}, 1'b0, 16, 1'b1, 1'b1);
        send({$urandom, $urandom}, 1'b1, TO, 1'b0, 1'b0);
        drain();

        // Reset in RUN: outputs return to idle and the block is dropped.
        send({$urandom, $urandom}, 1'b1, 40, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        sb.delete();
`ifdef CBC_MODE_EN
        chain = '0;
`endif
        #1 check_idle("reset in run");
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        for (int i = 0; i < 80; i++) begin
            r    = $urandom_range(0, 19);
            hang = (r == 0);
            lat  = (r == 1) ? TO : $urandom_range(1, 20);
            ec   = hang && ($urandom_range(0, 1) == 1);
`ifdef CBC_MODE_EN
            pend_ld = ($urandom_range(0, 3) == 0);
            pend_iv = {$urandom, $urandom};
`endif
            send({$urandom, $urandom}, 1'($urandom_range(0, 1)), lat, hang, ec);
        end
        drain();
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
